// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, controller state
// encoding and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers, fixed
// per-op latency, cancel (flush) and move-to-HI/LO support.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; MTHI/MTLO write HI/LO directly here
// ST_RUN  | multiply/divide in flight; counter counts down to commit
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] stage_hi_q, stage_hi_d, stage_lo_q, stage_lo_d;
  logic             staged_q, staged_d;
  logic             done_q, done_d;

  // Result datapath, driven only by the latched operands
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, div_b, q_mag, r_mag, q_sgn, r_sgn;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide via magnitudes avoids the most-negative / -1 overflow case
    a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    div_b = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag = a_mag / div_b;
    r_mag = a_mag % div_b;
    q_sgn = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_sgn = a_neg ? -r_mag : r_mag;

    res_hi = '0;
    res_lo = '0;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q == '0) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = r_sgn;
          res_lo = q_sgn;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stage_hi_d = stage_hi_q;
    stage_lo_d = stage_lo_q;
    staged_d   = staged_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (is_mul(op) || is_div(op)) begin
            op_d     = op;
            a_d      = src_a;
            b_d      = src_b;
            cnt_d    = is_mul(op) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            staged_d = 1'b0;
            state_d  = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = src_a;
          end else if (op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      ST_RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          // Single-cycle latency commits before the staging register is loaded
          hi_d    = staged_q ? stage_hi_q : res_hi;
          lo_d    = staged_q ? stage_lo_q : res_lo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          stage_hi_d = res_hi;
          stage_lo_d = res_lo;
          staged_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      stage_hi_q <= '0;
      stage_lo_q <= '0;
      staged_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      stage_hi_q <= stage_hi_d;
      stage_lo_q <= stage_lo_d;
      staged_q   <= staged_d;
      done_q     <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: reference model feeds a queue of expected
// HI/LO pairs that are popped when the unit signals done.
module tb_md_unit;
  import md_pkg::*;

  localparam int W    = 32;
  localparam int NMUL = 5;
  localparam int NDIV = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         cancel = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0]  exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  md_unit #(.WIDTH(W), .MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] r64;
    sa = $signed(a);
    sb = $signed(b);
    r64 = '0;
    case (o)
      OP_MULT:  r64 = sa * sb;
      OP_MULTU: r64 = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) r64 = {a, 32'hFFFF_FFFF};
        else begin
          sq  = sa / sb;
          sr  = sa % sb;
          r64 = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) r64 = {a, 32'hFFFF_FFFF};
        else r64 = {a % b, a / b};
      end
      default: r64 = {m_hi, m_lo};
    endcase
    return r64;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string name);
    int bc;
    logic [63:0] e;
    exp_q.push_back(model(o, a, b));
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < n + 5) begin
      bc++;
      vec_cnt++;
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s_hold: hi=%h lo=%h done=%b, want hi=%h lo=%h done=0",
                 name, hi, lo, done, m_hi, m_lo);
      end
      tick();
    end
    vec_cnt++;
    if (bc != n) begin
      err_cnt++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, n);
    end
    vec_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_done: got %b, want 1", name, done);
    end
    e = exp_q.pop_front();
    {m_hi, m_lo} = e;
    vec_cnt++;
    if (hi !== m_hi || lo !== m_lo) begin
      err_cnt++;
      $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
    tick();
    vec_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_done_width: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    vec_cnt++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all 0", hi, lo, busy, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, NMUL, "mult_neg3x5");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NMUL, "multu_max");
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, NMUL, "mult_minxmin");
  endtask

  task automatic test_div();
    run_op(OP_DIVU, 32'd100, 32'd7, NDIV, "divu_100_7");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, NDIV, "div_m7_2");
    run_op(OP_DIV, 32'h1234_5678, 32'd0, NDIV, "div_by_zero");
    run_op(OP_DIVU, 32'hDEAD_BEEF, 32'd0, NDIV, "divu_by_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, "div_overflow");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, "divu_big");
  endtask

  task automatic test_cancel();
    start = 1'b1; op = OP_MULTU; src_a = 32'h1234; src_b = 32'h5678;
    tick();
    start = 1'b0;
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      err_cnt++;
      $display("FAIL cancel: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
               busy, done, hi, lo, m_hi, m_lo);
    end
    for (int i = 0; i < NMUL; i++) begin
      tick();
      vec_cnt++;
      if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        err_cnt++;
        $display("FAIL cancel_late_done: done=%b hi=%h lo=%h", done, hi, lo);
      end
    end
    // Cancel on the completing edge suppresses the commit
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < NMUL - 1; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      err_cnt++;
      $display("FAIL cancel_nth: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
               busy, done, hi, lo, m_hi, m_lo);
    end
    tick();
    run_op(OP_MULTU, 32'h1234, 32'h5678, NMUL, "multu_after_cancel");
  endtask

  task automatic test_mt();
    int bc;
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    exp_q.push_back(model(OP_DIVU, 32'd100, 32'd7));
    tick();
    op = OP_MTLO; src_a = 32'hA5A5_A5A5;
    tick();
    start = 1'b0;
    bc = 1;
    while (busy === 1'b1 && bc < NDIV + 5) begin
      bc++;
      tick();
    end
    {m_hi, m_lo} = exp_q.pop_front();
    vec_cnt++;
    if (bc != NDIV || lo !== m_lo || hi !== m_hi || done !== 1'b1) begin
      err_cnt++;
      $display("FAIL mtlo_busy_ignored: cycles=%0d hi=%h lo=%h done=%b, want %0d %h %h 1",
               bc, hi, lo, done, NDIV, m_hi, m_lo);
    end
    tick();
    start = 1'b1; op = OP_MTLO; src_a = 32'hA5A5_A5A5;
    tick();
    start = 1'b0;
    m_lo = 32'hA5A5_A5A5;
    vec_cnt++;
    if (lo !== m_lo || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL mtlo_idle: hi=%h lo=%h busy=%b done=%b, want %h %h 0 0",
               hi, lo, busy, done, m_hi, m_lo);
    end
    start = 1'b1; op = OP_MTHI; src_a = 32'h3C3C_0F0F;
    tick();
    start = 1'b0;
    m_hi = 32'h3C3C_0F0F;
    vec_cnt++;
    if (lo !== m_lo || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL mthi_idle: hi=%h lo=%h busy=%b done=%b, want %h %h 0 0",
               hi, lo, busy, done, m_hi, m_lo);
    end
    start = 1'b1; op = 3'd6; src_a = 32'h1111_2222; src_b = 32'd3;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    vec_cnt++;
    if (lo !== m_lo || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL undefined_op: hi=%h lo=%h busy=%b done=%b, want %h %h 0 0",
               hi, lo, busy, done, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    vec_cnt++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b, want all 0", hi, lo, busy, done);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < NDIV; i++) begin
      tick();
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) begin
        err_cnt++;
        $display("FAIL reset_discard: done=%b busy=%b hi=%h lo=%h, want 0 0 0 0",
                 done, busy, hi, lo);
      end
    end
    run_op(OP_DIV, 32'd1000, 32'd3, NDIV, "div_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i % 4);
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      if (i == 6) b = 32'hFFFF_FFFF;
      run_op(o, a, b, is_mul(o) ? NMUL : NDIV, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_cancel();
    test_mt();
    test_reset_mid();
    test_back_to_back();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, multiply latency in cycles (legal >=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, divide latency in cycles (legal >=1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to begin the operation on op.
REQ-007 SHALL have port op, input, 3, operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 SHALL have port src_a, input, WIDTH, multiplicand/dividend/MT data.
REQ-009 SHALL have port src_b, input, WIDTH, multiplier/divisor.
REQ-010 SHALL have port cancel, input, 1, abort of the in-flight operation (pipeline flush).
REQ-011 SHALL have port hi, output, WIDTH, HI register.
REQ-012 SHALL have port lo, output, WIDTH, LO register.
REQ-013 SHALL have port busy, output, 1, high while a multiply/divide is in flight.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL use two states, IDLE and RUN; busy = (state == RUN), registered.
REQ-016 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch op, src_a and src_b at that edge, load the counter with MUL_CYCLES or DIV_CYCLES, and enter RUN.
REQ-017 busy SHALL be high for exactly N cycles after the accepting edge, where N is the latency for op.
REQ-018 On the Nth edge, HI/LO SHALL update, state SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-019 MULT/MULTU SHALL form the signed/unsigned 2*WIDTH product: upper half to HI, lower half to LO.
REQ-020 DIV/DIVU SHALL place the quotient (truncated toward zero) in LO and the remainder (sign of the dividend) in HI.
REQ-021 Divide by zero SHALL give LO = all ones and HI = src_a, for both DIV and DIVU.
REQ-022 DIV with most-negative / -1 SHALL give LO = most-negative and HI = 0.
REQ-023 MTHI/MTLO with start in IDLE SHALL write src_a to HI/LO at that edge, without entering RUN and without pulsing done.
REQ-024 start in RUN SHALL be ignored for every op; the requester keeps it stalled on busy.
REQ-025 cancel in RUN SHALL return to IDLE at the next edge: HI/LO unchanged, no done pulse.
REQ-026 cancel has priority over start; a start in the same cycle as cancel SHALL be ignored.
REQ-027 cancel in IDLE SHALL have no effect.
REQ-028 cancel on the completing (Nth) edge SHALL suppress the HI/LO update and the done pulse.
REQ-029 hi/lo SHALL hold their previous values throughout RUN.
REQ-030 An undefined op with start SHALL be ignored.

Reset
REQ-031 reset SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 immediately, independent of clk.
REQ-032 reset during RUN SHALL discard the operation; the first start after reset release SHALL be accepted normally.

Structure
REQ-033 The op encodings, the state encoding and the default latency constants SHALL live in shared package md_pkg, reused by the controller and the hazard unit.
REQ-034 The result SHALL be computed from the latched operands and held in a staging register until the Nth edge.
REQ-035 The counter width SHALL be clog2(max(MUL_CYCLES, DIV_CYCLES) + 1).
REQ-036 The block SHALL be a single module; no sub-module is required.

Verification (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10)
REQ-037 MULT src_a=-3, src_b=5 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, done pulse of one cycle.
REQ-038 DIVU 100/7 -> LO=14, HI=2 after 10 cycles; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-039 DIV 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-040 MULTU started, cancel in cycle 3 -> busy low next cycle, HI/LO unchanged, no done; a new MULTU is then accepted.
REQ-041 MTLO 0xA5A5A5A5 while busy -> ignored; the same MTLO in IDLE -> LO=0xA5A5A5A5 at the next edge, busy stays 0.
REQ-042 reset asserted in cycle 6 of a DIV -> hi=lo=0 and busy=0 immediately; no done after release.
